// File: rtl/crc_engine.sv
// rtl/crc_engine.sv - streaming CRC engine, DATA_W bits per beat, frame-based with residue check
//
// Ports:
//   clk_i        single clock, rising edge
//   rstn_i       asynchronous active-low reset
//   valid_i      data_i holds a beat to consume this cycle (no backpressure)
//   data_i       beat data, MSB processed first
//   last_i       current valid beat closes the frame
//   abort_i      drop the open frame (and any beat presented with it)
//   busy_o       a frame is open (RUN)
//   crc_o        final CRC (register ^ XOR_OUT) of the latest completed frame
//   crc_valid_o  one-cycle pulse when crc_o/match_o/len_o update
//   match_o      latest completed frame left the raw register equal to RESIDUE
//   len_o        beat count of the latest completed frame (saturating)
module crc_engine #(
    parameter int                 CRC_W   = 16,
    parameter logic [CRC_W-1:0]   POLY    = 16'h1021,
    parameter logic [CRC_W-1:0]   INIT    = 16'hFFFF,
    parameter logic [CRC_W-1:0]   XOR_OUT = 16'h0000,
    parameter logic [CRC_W-1:0]   RESIDUE = 16'h0000,
    parameter int                 DATA_W  = 8,
    parameter int                 LEN_W   = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic [CRC_W-1:0]  crc_o,
    output logic              crc_valid_o,
    output logic              match_o,
    output logic [LEN_W-1:0]  len_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [CRC_W-1:0] crc_q;
    logic [LEN_W-1:0] cnt_q;

    logic [CRC_W-1:0] crc_next;
    logic [LEN_W-1:0] cnt_next;
    logic             fb;

    assign busy_o = (state == ST_RUN);

    // A beat accepted outside RUN opens a new frame, so it is seeded from INIT
    // rather than whatever the previous frame left in the register.
    always_comb begin
        crc_next = (state == ST_RUN) ? crc_q : INIT;
        fb       = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            fb       = crc_next[CRC_W-1] ^ data_i[DATA_W-1-i];
            crc_next = {crc_next[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
        end
    end

    always_comb begin
        if (state != ST_RUN)
            cnt_next = LEN_W'(1);
        else if (cnt_q == {LEN_W{1'b1}})
            cnt_next = cnt_q;
        else
            cnt_next = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= ST_IDLE;
            crc_q       <= INIT;
            cnt_q       <= '0;
            crc_o       <= '0;
            crc_valid_o <= 1'b0;
            match_o     <= 1'b0;
            len_o       <= '0;
        end else begin
            crc_valid_o <= 1'b0;
            if (abort_i) begin
                // Abort wins over a simultaneous beat, including a last beat.
                state <= ST_IDLE;
                crc_q <= INIT;
                cnt_q <= '0;
            end else if (valid_i) begin
                crc_q <= crc_next;
                cnt_q <= cnt_next;
                if (last_i) begin
                    state       <= ST_DONE;
                    crc_o       <= crc_next ^ XOR_OUT;
                    match_o     <= (crc_next == RESIDUE);
                    len_o       <= cnt_next;
                    crc_valid_o <= 1'b1;
                end else begin
                    state <= ST_RUN;
                end
            end else if (state != ST_RUN) begin
                // DONE lasts one cycle; idle cycles inside RUN hold everything.
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_crc_engine.sv
// tb/tb_crc_engine.sv - scoreboard bench for crc_engine across four parameter sets
module tb_crc_engine;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // shared byte-wide stimulus for dut_a (defaults), dut_b (INIT=0), dut_d (LEN_W=4)
    logic       valid, last, abort;
    logic [7:0] data;
    // bit-serial stimulus for dut_c (DATA_W=1, INIT=0)
    logic       valid1, last1, abort1;
    logic [0:0] data1;

    logic        busy_a, cv_a, match_a; logic [15:0] crc_a, len_a;
    logic        busy_b, cv_b, match_b; logic [15:0] crc_b, len_b;
    logic        busy_c, cv_c, match_c; logic [15:0] crc_c, len_c;
    logic        busy_d, cv_d, match_d; logic [15:0] crc_d; logic [3:0] len_d;

    crc_engine dut_a (
        .clk_i(clk), .rstn_i(rstn), .valid_i(valid), .data_i(data), .last_i(last), .abort_i(abort),
        .busy_o(busy_a), .crc_o(crc_a), .crc_valid_o(cv_a), .match_o(match_a), .len_o(len_a));

    crc_engine #(.INIT(16'h0000)) dut_b (
        .clk_i(clk), .rstn_i(rstn), .valid_i(valid), .data_i(data), .last_i(last), .abort_i(abort),
        .busy_o(busy_b), .crc_o(crc_b), .crc_valid_o(cv_b), .match_o(match_b), .len_o(len_b));

    crc_engine #(.INIT(16'h0000), .DATA_W(1)) dut_c (
        .clk_i(clk), .rstn_i(rstn), .valid_i(valid1), .data_i(data1), .last_i(last1), .abort_i(abort1),
        .busy_o(busy_c), .crc_o(crc_c), .crc_valid_o(cv_c), .match_o(match_c), .len_o(len_c));

    crc_engine #(.LEN_W(4)) dut_d (
        .clk_i(clk), .rstn_i(rstn), .valid_i(valid), .data_i(data), .last_i(last), .abort_i(abort),
        .busy_o(busy_d), .crc_o(crc_d), .crc_valid_o(cv_d), .match_o(match_d), .len_o(len_d));

    typedef struct {
        logic [15:0] crc;
        logic        match;
        logic [15:0] len;
    } exp_t;

    exp_t qa[$], qb[$], qc[$], qd[$];
    int n_checks = 0;
    int n_fail   = 0;
    int pulses_a = 0, pulses_b = 0, pulses_c = 0, pulses_d = 0;
    logic [7:0] frame[$];
    logic       bits[$];

    // Reference CRC-16/0x1021, MSB-first over the low nb bits of d.
    function automatic logic [15:0] step(input logic [15:0] c, input logic [7:0] d, input int nb);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < nb; i++) begin
            if (r[15] ^ d[nb-1-i]) r = (r << 1) ^ 16'h1021;
            else                   r = r << 1;
        end
        return r;
    endfunction

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) if (rstn === 1'b1 && cv_a === 1'b1) begin
        exp_t e;
        pulses_a++; n_checks++;
        if (qa.size() == 0) begin
            n_fail++; $display("FAIL sb_a unexpected pulse: crc=%h len=%0d, expected no pulse", crc_a, len_a);
        end else begin
            e = qa.pop_front();
            if (crc_a !== e.crc || match_a !== e.match || len_a !== e.len) begin
                n_fail++; $display("FAIL sb_a: got crc=%h match=%b len=%0d, expected crc=%h match=%b len=%0d",
                                   crc_a, match_a, len_a, e.crc, e.match, e.len);
            end
        end
    end

    always @(negedge clk) if (rstn === 1'b1 && cv_b === 1'b1) begin
        exp_t e;
        pulses_b++; n_checks++;
        if (qb.size() == 0) begin
            n_fail++; $display("FAIL sb_b unexpected pulse: crc=%h len=%0d, expected no pulse", crc_b, len_b);
        end else begin
            e = qb.pop_front();
            if (crc_b !== e.crc || match_b !== e.match || len_b !== e.len) begin
                n_fail++; $display("FAIL sb_b: got crc=%h match=%b len=%0d, expected crc=%h match=%b len=%0d",
                                   crc_b, match_b, len_b, e.crc, e.match, e.len);
            end
        end
    end

    always @(negedge clk) if (rstn === 1'b1 && cv_c === 1'b1) begin
        exp_t e;
        pulses_c++; n_checks++;
        if (qc.size() == 0) begin
            n_fail++; $display("FAIL sb_c unexpected pulse: crc=%h len=%0d, expected no pulse", crc_c, len_c);
        end else begin
            e = qc.pop_front();
            if (crc_c !== e.crc || match_c !== e.match || len_c !== e.len) begin
                n_fail++; $display("FAIL sb_c: got crc=%h match=%b len=%0d, expected crc=%h match=%b len=%0d",
                                   crc_c, match_c, len_c, e.crc, e.match, e.len);
            end
        end
    end

    always @(negedge clk) if (rstn === 1'b1 && cv_d === 1'b1) begin
        exp_t e;
        pulses_d++; n_checks++;
        if (qd.size() == 0) begin
            n_fail++; $display("FAIL sb_d unexpected pulse: crc=%h len=%0d, expected no pulse", crc_d, len_d);
        end else begin
            e = qd.pop_front();
            if (crc_d !== e.crc || match_d !== e.match || len_d !== e.len[3:0]) begin
                n_fail++; $display("FAIL sb_d: got crc=%h match=%b len=%0d, expected crc=%h match=%b len=%0d",
                                   crc_d, match_d, len_d, e.crc, e.match, e.len[3:0]);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk); #1;
            valid = 1'b0; last = 1'b0; abort = 1'b0;
            valid1 = 1'b0; last1 = 1'b0; abort1 = 1'b0;
        end
    endtask

    task automatic drive_beat(input logic [7:0] d, input logic l);
        @(posedge clk); #1;
        valid = 1'b1; data = d; last = l; abort = 1'b0;
    endtask

    task automatic drive_bit(input logic b, input logic l);
        @(posedge clk); #1;
        valid1 = 1'b1; data1 = b; last1 = l; abort1 = 1'b0;
    endtask

    // Pushes the expected result of `frame` for dut_a/b/d, then drives it.
    task automatic send_frame();
        logic [15:0] ca, cb;
        int n;
        exp_t e;
        ca = 16'hFFFF; cb = 16'h0000; n = frame.size();
        for (int i = 0; i < n; i++) begin
            ca = step(ca, frame[i], 8);
            cb = step(cb, frame[i], 8);
        end
        e.crc = ca; e.match = (ca == 16'h0000); e.len = (n > 65535) ? 16'hFFFF : 16'(n); qa.push_back(e);
        e.crc = cb; e.match = (cb == 16'h0000); qb.push_back(e);
        e.crc = ca; e.match = (ca == 16'h0000); e.len = (n > 15) ? 16'd15 : 16'(n); qd.push_back(e);
        for (int i = 0; i < n; i++) drive_beat(frame[i], (i == n - 1));
    endtask

    task automatic send_bits();
        logic [15:0] c;
        int n;
        exp_t e;
        c = 16'h0000; n = bits.size();
        for (int i = 0; i < n; i++) c = step(c, {7'd0, bits[i]}, 1);
        e.crc = c; e.match = (c == 16'h0000); e.len = 16'(n); qc.push_back(e);
        for (int i = 0; i < n; i++) drive_bit(bits[i], (i == n - 1));
    endtask

    task automatic load_ascii();
        frame.delete();
        for (int i = 1; i <= 9; i++) frame.push_back(8'(8'h30 + i));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        valid = 0; last = 0; abort = 0; data = 0;
        valid1 = 0; last1 = 0; abort1 = 0; data1 = 0;
        @(posedge clk); #1;
        n_checks++; if ({busy_a, cv_a, match_a, crc_a, len_a} !== 35'd0) begin
            n_fail++; $display("FAIL reset_a: got %h, expected 0", {busy_a, cv_a, match_a, crc_a, len_a}); end
        n_checks++; if ({busy_b, cv_b, match_b, crc_b, len_b} !== 35'd0) begin
            n_fail++; $display("FAIL reset_b: got %h, expected 0", {busy_b, cv_b, match_b, crc_b, len_b}); end
        n_checks++; if ({busy_c, cv_c, match_c, crc_c, len_c} !== 35'd0) begin
            n_fail++; $display("FAIL reset_c: got %h, expected 0", {busy_c, cv_c, match_c, crc_c, len_c}); end
        n_checks++; if ({busy_d, cv_d, match_d, crc_d, len_d} !== 23'd0) begin
            n_fail++; $display("FAIL reset_d: got %h, expected 0", {busy_d, cv_d, match_d, crc_d, len_d}); end
        @(posedge clk); #1;
        rstn = 1'b1;
        idle(2);
    endtask

    task automatic test_known_vector();
        int p0;
        p0 = pulses_a;
        load_ascii();
        send_frame();
        idle(1);
        @(negedge clk);
        n_checks++; if (cv_a !== 1'b1) begin
            n_fail++; $display("FAIL latency: crc_valid got %b, expected 1", cv_a); end
        n_checks++; if (crc_a !== 16'h29B1 || len_a !== 16'd9) begin
            n_fail++; $display("FAIL ascii_ffff: got crc=%h len=%0d, expected 29b1 len=9", crc_a, len_a); end
        n_checks++; if (crc_b !== 16'h31C3) begin
            n_fail++; $display("FAIL ascii_0000: got crc=%h, expected 31c3", crc_b); end
        @(negedge clk);
        n_checks++; if (cv_a !== 1'b0) begin
            n_fail++; $display("FAIL pulse_width: crc_valid got %b, expected 0", cv_a); end
        idle(3);
        n_checks++; if (pulses_a !== p0 + 1) begin
            n_fail++; $display("FAIL single_pulse: got %0d pulses, expected 1", pulses_a - p0); end
    endtask

    task automatic test_residue();
        load_ascii();
        frame.push_back(8'h31);
        frame.push_back(8'hC3);
        send_frame();
        idle(1);
        @(negedge clk);
        n_checks++; if (match_b !== 1'b1 || len_b !== 16'd11) begin
            n_fail++; $display("FAIL residue_byte: got match=%b len=%0d, expected match=1 len=11", match_b, len_b); end
        idle(2);
    endtask

    task automatic test_bitwise();
        logic [15:0] c;
        bits.delete();
        c = 16'h0000;
        for (int i = 0; i < 144; i++) begin
            bits.push_back(1'($urandom_range(0, 1)));
            c = step(c, {7'd0, bits[i]}, 1);
        end
        for (int i = 15; i >= 0; i--) bits.push_back(c[i]);
        send_bits();
        idle(1);
        @(negedge clk);
        n_checks++; if (match_c !== 1'b1 || len_c !== 16'd160) begin
            n_fail++; $display("FAIL residue_bit: got match=%b len=%0d, expected match=1 len=160", match_c, len_c); end
        idle(2);
        bits[150] = ~bits[150];
        send_bits();
        idle(1);
        @(negedge clk);
        n_checks++; if (match_c !== 1'b0 || len_c !== 16'd160) begin
            n_fail++; $display("FAIL residue_flip: got match=%b len=%0d, expected match=0 len=160", match_c, len_c); end
        idle(2);
    endtask

    task automatic test_back_to_back();
        int p0;
        logic [7:0] f3[$];
        p0 = pulses_a;
        frame.delete(); for (int i = 0; i < 5; i++) frame.push_back(8'($urandom));
        send_frame();
        frame.delete(); for (int i = 0; i < 3; i++) frame.push_back(8'($urandom));
        send_frame();
        f3.delete(); for (int i = 0; i < 6; i++) f3.push_back(8'($urandom));
        for (int i = 0; i < 3; i++) drive_beat(f3[i], 1'b0);
        @(posedge clk); #1; valid = 1'b0; last = 1'b1;   // last without valid: ignored
        @(negedge clk);
        n_checks++; if (busy_a !== 1'b1) begin
            n_fail++; $display("FAIL last_no_valid: busy got %b, expected 1", busy_a); end
        drive_beat(f3[3], 1'b0);
        @(posedge clk); #1; valid = 1'b1; last = 1'b1; abort = 1'b1; data = f3[4];
        idle(3);
        n_checks++; if (busy_a !== 1'b0 || pulses_a !== p0 + 2) begin
            n_fail++; $display("FAIL abort: got busy=%b pulses=%0d, expected busy=0 pulses=2", busy_a, pulses_a - p0); end
        frame = f3;
        send_frame();
        idle(3);
        n_checks++; if (pulses_a !== p0 + 3) begin
            n_fail++; $display("FAIL replay: got %0d pulses, expected 3", pulses_a - p0); end
    endtask

    task automatic test_len_sat();
        frame.delete(); for (int i = 0; i < 20; i++) frame.push_back(8'($urandom));
        send_frame();
        idle(1);
        @(negedge clk);
        n_checks++; if (len_d !== 4'd15 || len_a !== 16'd20) begin
            n_fail++; $display("FAIL len_sat: got len_d=%0d len_a=%0d, expected 15 and 20", len_d, len_a); end
        idle(2);
        frame.delete(); frame.push_back(8'hA5);
        send_frame();
        idle(1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++; if (busy_d !== 1'b0) begin
                n_fail++; $display("FAIL single_busy: busy got %b, expected 0", busy_d); end
        end
        n_checks++; if (len_d !== 4'd1) begin
            n_fail++; $display("FAIL single_len: got %0d, expected 1", len_d); end
        idle(2);
    endtask

    task automatic test_reset_mid();
        int p0;
        p0 = pulses_a;
        load_ascii();
        for (int i = 0; i < 3; i++) drive_beat(frame[i], 1'b0);
        #2; rstn = 1'b0;
        #1;
        n_checks++; if ({busy_a, cv_a, match_a, crc_a, len_a} !== 35'd0) begin
            n_fail++; $display("FAIL reset_mid: got %h, expected 0", {busy_a, cv_a, match_a, crc_a, len_a}); end
        @(posedge clk); #1;
        valid = 1'b0; rstn = 1'b1;
        idle(2);
        n_checks++; if (pulses_a !== p0) begin
            n_fail++; $display("FAIL reset_no_pulse: got %0d pulses, expected 0", pulses_a - p0); end
        send_frame();
        idle(1);
        @(negedge clk);
        n_checks++; if (crc_a !== 16'h29B1) begin
            n_fail++; $display("FAIL reset_after: got crc=%h, expected 29b1", crc_a); end
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_known_vector();
        test_residue();
        test_bitwise();
        test_back_to_back();
        test_len_sat();
        test_reset_mid();
        idle(3);
        n_checks++; if (qa.size() + qb.size() + qc.size() + qd.size() !== 0) begin
            n_fail++; $display("FAIL drain: %0d expected results never produced, expected 0",
                               qa.size() + qb.size() + qc.size() + qd.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
